// File: rtl/dnn_pkg.sv
// Shared opcodes, controller states and the saturation helper for the DNN layer controller.
package dnn_pkg;

  // Working width for saturation; wide enough for any accumulator this block builds.
  localparam int SAT_W = 128;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LOAD_W = 4'd1,
    OP_LOAD_X = 4'd2,
    OP_RUN    = 4'd3,
    OP_READ   = 4'd4
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_X,
    ST_RUN,
    ST_READ
  } state_e;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/dnn_mac_sat.sv
// Combinational multiply-accumulate with output scaling, saturation and optional ReLU.
module dnn_mac_sat
  import dnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 67,
  parameter int FRAC   = 0
)(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     relu,
  output logic signed [ACC_W-1:0]  acc_sum,
  output logic signed [DATA_W-1:0] y
);

  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] shifted;
  logic signed [SAT_W-1:0] clamped;

  // Add this product to the running sum, then scale, clamp and rectify it as a row result.
  always_comb begin
    prod    = ACC_W'(w) * ACC_W'(x);
    acc_sum = acc + prod;
    shifted = acc_sum >>> FRAC;
    clamped = saturate(SAT_W'(shifted), DATA_W);
    y       = clamped[DATA_W-1:0];
    if (relu && y[DATA_W-1]) y = '0;
  end

endmodule

// File: rtl/dnn_layer_ctrl.sv
// Fully-connected layer controller: loads weights and activations, runs a serial MAC, reads results.
module dnn_layer_ctrl
  import dnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 8,
  parameter int N_OUT  = 4,
  parameter int FRAC   = 0
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              mode,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int N_W   = N_IN * N_OUT;
  localparam int IDX_W = $clog2(N_W);
  localparam int COL_W = $clog2(N_IN);
  localparam int ROW_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(N_W - 1);
  localparam logic [IDX_W-1:0] LAST_X = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] LAST_Y = IDX_W'(N_OUT - 1);
  localparam logic [COL_W-1:0] LAST_C = COL_W'(N_IN - 1);

  state_e                   state;
  state_e                   state_next;
  state_e                   cur_state;
  logic [31:0]              mode_q;
  logic                     relu_q;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         cur_idx;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [DATA_W-1:0] y_val;
  logic                     cmd_change;
  logic                     last_mac;

  logic signed [DATA_W-1:0] w_mem [N_W];
  logic signed [DATA_W-1:0] x_mem [N_IN];
  logic signed [DATA_W-1:0] y_mem [N_OUT];

  dnn_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .FRAC   (FRAC)
  ) u_mac (
    .acc     (acc),
    .w       (w_mem[idx]),
    .x       (x_mem[col]),
    .relu    (relu_q),
    .acc_sum (acc_sum),
    .y       (y_val)
  );

  // State register; holds its value on disabled cycles.
  always_ff @(posedge clk) begin
    if (reset)       state <= ST_IDLE;
    else if (enable) state <= state_next;
  end

  // Decode a new command word (ignored while running) and pick the state acting this cycle.
  always_comb begin
    state_next = state;
    busy       = (state == ST_RUN);
    cmd_change = enable && (mode != mode_q) && (state != ST_RUN);
    last_mac   = enable && (state == ST_RUN) && (idx == LAST_W);
    if (cmd_change) begin
      case (mode[3:0])
        OP_LOAD_W: state_next = ST_LOAD_W;
        OP_LOAD_X: state_next = ST_LOAD_X;
        OP_RUN:    state_next = ST_RUN;
        OP_READ:   state_next = ST_READ;
        default:   state_next = ST_IDLE;
      endcase
    end else if (last_mac) begin
      state_next = ST_IDLE;
    end
    cur_state = cmd_change ? state_next : state;
    cur_idx   = cmd_change ? '0 : idx;
  end

  // Datapath: buffer writes, MAC sequencing, result readout and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= '0;
      relu_q    <= 1'b0;
      idx       <= '0;
      col       <= '0;
      row       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N_W; i++)   w_mem[i] <= '0;
      for (int i = 0; i < N_IN; i++)  x_mem[i] <= '0;
      for (int i = 0; i < N_OUT; i++) y_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (enable) begin
        mode_q    <= mode;
        out_valid <= 1'b0;
        if (cmd_change) begin
          idx    <= '0;
          col    <= '0;
          row    <= '0;
          acc    <= '0;
          relu_q <= mode[8];
        end
        case (cur_state)
          ST_LOAD_W: begin
            w_mem[cur_idx] <= in_data;
            idx <= (cur_idx == LAST_W) ? '0 : cur_idx + 1'b1;
          end
          ST_LOAD_X: begin
            x_mem[cur_idx[COL_W-1:0]] <= in_data;
            idx <= (cur_idx == LAST_X) ? '0 : cur_idx + 1'b1;
          end
          ST_READ: begin
            out_data  <= y_mem[cur_idx[ROW_W-1:0]];
            out_valid <= 1'b1;
            idx <= (cur_idx == LAST_Y) ? '0 : cur_idx + 1'b1;
          end
          ST_RUN: begin
            if (!cmd_change) begin
              idx <= last_mac ? '0 : idx + 1'b1;
              if (col == LAST_C) begin
                y_mem[row] <= y_val;
                acc        <= '0;
                col        <= '0;
                row        <= row + 1'b1;
              end else begin
                acc <= acc_sum;
                col <= col + 1'b1;
              end
              if (last_mac) done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/dnn_layer_ctrl.md
DNN_LAYER_CTRL -- requirements
Module: dnn_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed data/weight width.
REQ-002 SHALL have parameter N_IN, default 8: input-vector length (>=2).
REQ-003 SHALL have parameter N_OUT, default 4: output-vector length (>=1).
REQ-004 SHALL have parameter FRAC, default 0: right-shift applied to accumulator before output.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1: global clock-enable; low freezes all state and outputs.
REQ-008 SHALL have port mode  input  32: command word; [3:0] opcode, [8] relu, others reserved/ignored.
REQ-009 SHALL have port in_data  input  DATA_W signed: weight/activation stream.
REQ-010 SHALL have port out_data  output  DATA_W signed: registered result stream.
REQ-011 SHALL have port out_valid  output  1: out_data holds a READ result.
REQ-012 SHALL have port busy  output  1: RUN in progress.
REQ-013 SHALL have port done  output  1: one-cycle pulse when RUN completes.

Function
REQ-014 SHALL decode opcodes: 0 NOP, 1 LOAD_W, 2 LOAD_X, 3 RUN, 4 READ; 5-15 treated as NOP.
REQ-015 SHALL start a command on an enabled cycle where mode differs from mode registered on the previous enabled cycle and opcode is non-zero; start resets the index counter to 0.
REQ-016 SHALL, in LOAD_W, write in_data to W[idx] each enabled cycle from the start cycle, idx row-major (row*N_IN+col), wrapping from N_IN*N_OUT-1 to 0.
REQ-017 SHALL, in LOAD_X, write in_data to X[idx] each enabled cycle, wrapping from N_IN-1 to 0.
REQ-018 SHALL, in RUN, perform one signed MAC (acc += W[r][c]*X[c]) per enabled cycle, N_IN*N_OUT cycles total; busy high for exactly those cycles.
REQ-019 SHALL use accumulator width 2*DATA_W+clog2(N_IN); no intermediate overflow.
REQ-020 SHALL, at each row end, write Y[r] = sat(acc >>> FRAC) to DATA_W (clamp to max/min signed), then 0 if relu=1 and value negative; clear acc.
REQ-021 SHALL pulse done for one cycle on the cycle after the last Y write, and return to IDLE.
REQ-022 SHALL ignore all mode changes while busy=1; the mode register still tracks mode so no command fires at RUN end unless mode changes again.
REQ-023 SHALL, in READ, drive out_data=Y[idx] one cycle after each enabled cycle with out_valid=1, idx wrapping N_OUT-1 to 0.
REQ-024 SHALL hold out_data at last value with out_valid=0 outside READ.
REQ-025 SHALL, when enable=0, freeze counters, accumulator, buffers, mode register and outputs (done held low).
REQ-026 SHALL implement states IDLE, LOAD_W, LOAD_X, RUN, READ; opcode change from any non-RUN state goes directly to the new state.

Reset
REQ-027 SHALL on reset clear out_data, out_valid, busy, done, idx, acc, registered mode to 0 and enter IDLE; reset overrides enable.
REQ-028 SHALL clear W, X, Y to zero on reset; reset mid-RUN aborts with no Y write.

Structure
REQ-029 SHALL place opcode enum, state enum and the saturate function in shared package dnn_pkg.
REQ-030 SHALL instantiate one sub-module dnn_mac_sat (multiply-accumulate, shift, saturate, relu).

Verification (N_IN=4, N_OUT=2, DATA_W=32, FRAC=0)
REQ-031 SHALL cover: reset asserted 1 cycle -> out_data=0, out_valid=0, busy=0, done=0.
REQ-032 SHALL cover: LOAD_W 1,2,3,4,-1,0,0,-4; LOAD_X 1,1,1,1; RUN -> busy 8 cycles, done pulse; READ -> 10, -5, 10.
REQ-033 SHALL cover: same data, RUN with mode[8]=1 -> READ 10, 0.
REQ-034 SHALL cover: W[0][0]=0x7FFFFFFF, X[0]=2 (rest 0) -> Y[0]=0x7FFFFFFF; W[0][0]=0x80000000 -> Y[0]=0x80000000.
REQ-035 SHALL cover: 9 LOAD_W words 1..9 -> W[0]=9 (wrap); enable low 3 cycles mid-RUN -> busy lasts 11 cycles, results unchanged.
REQ-036 SHALL cover: reset at RUN cycle 5 -> next cycle busy=0, done never pulses, READ returns 0, 0.
